// File: rtl/soc_mem_pkg.sv
// Memory-side definitions shared by inst_cache and line_fill_responder:
// line geometry, the responder state encoding and line alignment.
package soc_mem_pkg;

   localparam int LINE_BYTES       = 32;
   localparam int LINE_OFFSET_BITS = 5;
   localparam int LINE_WORDS       = 8;
   localparam int WORD_BITS        = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ACK   = 2'd2,
      DRAIN = 2'd3
   } fill_state_e;

   // Clears the byte offset within a line, giving the line base address.
   function automatic logic [31:0] line_base(input logic [31:0] addr);
      return addr & ~32'(LINE_BYTES - 1);
   endfunction

endpackage

// File: rtl/line_fill_responder.sv
// Memory-side responder for instruction-cache line fills: fetches the words
// of one line over a 32-bit bus and returns the assembled line with an ack pulse.
module line_fill_responder
   import soc_mem_pkg::*;
#(
   parameter int LINE_WORDS = 8,
   parameter int TIMEOUT    = 255
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [31:0]                     addr_i,
   input  logic                            rd_i,
   output logic [WORD_BITS*LINE_WORDS-1:0] data_o,
   output logic                            ack_o,
   output logic [31:0]                     mem_addr_o,
   output logic                            mem_rd_o,
   input  logic [31:0]                     mem_data_i,
   input  logic                            mem_valid_i,
   output logic                            err_o
);

   localparam int IdxW = $clog2(LINE_WORDS);
   localparam int CntW = $clog2(TIMEOUT + 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(LINE_WORDS - 1);
   localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT - 1);

   fill_state_e                     state_q;
   logic [IdxW-1:0]                 idx_q;
   logic [CntW-1:0]                 tmo_q;
   logic [31:0]                     addr_q;
   logic [WORD_BITS*LINE_WORDS-1:0] data_q;
   logic                            ack_q;
   logic                            rd_q;
   logic                            err_q;
   logic [WORD_BITS*LINE_WORDS-1:0] data_tmo_d;

   // On an aborted fill, the current word and everything above it were never
   // delivered, so the cache must see them as zero rather than a stale line.
   always_comb begin
      data_tmo_d = data_q;
      for (int k = 0; k < LINE_WORDS; k++) begin
         if (k >= int'(idx_q)) begin
            data_tmo_d[WORD_BITS*k +: WORD_BITS] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         tmo_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         ack_q   <= 1'b0;
         rd_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (rd_i) begin
                  addr_q  <= line_base(addr_i);
                  rd_q    <= 1'b1;
                  idx_q   <= '0;
                  tmo_q   <= '0;
                  state_q <= FETCH;
               end
            end
            // rd_i is deliberately not looked at here: the request is committed.
            FETCH: begin
               if (mem_valid_i) begin
                  data_q[WORD_BITS*int'(idx_q) +: WORD_BITS] <= mem_data_i;
                  tmo_q <= '0;
                  if (idx_q == IdxLast) begin
                     rd_q    <= 1'b0;
                     state_q <= ACK;
                  end else begin
                     idx_q  <= idx_q + IdxW'(1);
                     addr_q <= addr_q + 32'd4;
                  end
               end else if (tmo_q == TmoLast) begin
                  err_q   <= 1'b1;
                  rd_q    <= 1'b0;
                  data_q  <= data_tmo_d;
                  state_q <= ACK;
               end else begin
                  tmo_q <= tmo_q + CntW'(1);
               end
            end
            ACK: begin
               ack_q   <= 1'b1;
               state_q <= DRAIN;
            end
            // A request still held after the ack is stale; wait for it to drop.
            DRAIN: begin
               if (!rd_i) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign data_o     = data_q;
   assign ack_o      = ack_q;
   assign mem_addr_o = addr_q;
   assign mem_rd_o   = rd_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_line_fill_responder.sv
// Directed bench for line_fill_responder: a word=address memory model feeds the
// DUT and a queue of expected lines is checked against every ack_o pulse.
module tb_line_fill_responder;

   logic         clk;
   logic         rst;
   logic [31:0]  addr_i;
   logic         rd_i;
   logic [255:0] data_o;
   logic         ack_o;
   logic [31:0]  mem_addr_o;
   logic         mem_rd_o;
   logic [31:0]  mem_data_i;
   logic         mem_valid_i;
   logic         err_o;

   int total = 0;
   int bad = 0;
   int ackCount = 0;
   int memMode = 1;
   int stallAfter = 8;
   int wordsGiven = 0;
   int phase = 0;
   logic [255:0] expQ[$];

   line_fill_responder #(.LINE_WORDS(8), .TIMEOUT(16)) dut (
      .clk(clk),
      .rst(rst),
      .addr_i(addr_i),
      .rd_i(rd_i),
      .data_o(data_o),
      .ack_o(ack_o),
      .mem_addr_o(mem_addr_o),
      .mem_rd_o(mem_rd_o),
      .mem_data_i(mem_data_i),
      .mem_valid_i(mem_valid_i),
      .err_o(err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected line: word k holds its own byte address, words past nWords are zero.
   function automatic logic [255:0] expectLine(input logic [31:0] addr, input int nWords);
      logic [255:0] l;
      logic [31:0] base;
      base = addr & 32'hFFFF_FFE0;
      l = '0;
      for (int k = 0; k < 8; k++) begin
         if (k < nWords) l[32*k +: 32] = base + 32'(4*k);
      end
      return l;
   endfunction

   // Memory model: answers with its own address, either every cycle or every
   // third cycle, and goes silent after stallAfter words.
   initial begin
      mem_valid_i = 1'b0;
      mem_data_i  = '0;
      forever begin
         @(negedge clk);
         phase++;
         if (mem_rd_o && wordsGiven < stallAfter && (memMode == 1 || phase % 3 == 0)) begin
            mem_valid_i = 1'b1;
            mem_data_i  = mem_addr_o;
            wordsGiven++;
         end else begin
            mem_valid_i = 1'b0;
            mem_data_i  = 32'hDEAD_BEEF;
         end
      end
   end

   initial begin
      logic [255:0] e;
      forever begin
         @(negedge clk);
         if (rst && ack_o) begin
            ackCount++;
            if (expQ.size() == 0) begin
               checkOutput("spurious_ack", ack_o, 1'b0);
            end else begin
               e = expQ.pop_front();
               checkOutput("line_data", data_o, e);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Issues one request and waits for its ack; lat is edges after the sampling edge.
   task automatic applyStimulus(input logic [31:0] addr, input int validWords,
                                input bit toggleRd, output int lat);
      @(negedge clk);
      wordsGiven = 0;
      addr_i = addr;
      rd_i = 1'b1;
      expQ.push_back(expectLine(addr, validWords));
      @(posedge clk);
      lat = -1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (ack_o) begin
            lat = c;
            break;
         end
         if (toggleRd && mem_rd_o) rd_i = ~rd_i;
      end
      rd_i = 1'b1;
      checkOutput("ack_seen", lat >= 0, 1'b1);
   endtask

   // Holds the stale request for n cycles, then drops it for exactly one edge.
   task automatic releaseRd(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checkOutput("stale_no_mem_rd", mem_rd_o, 1'b0);
         checkOutput("ack_single_pulse", ack_o, 1'b0);
      end
      rd_i = 1'b0;
   endtask

   initial begin
      int lat;
      int ackBefore;
      rst = 1'b0;
      rd_i = 1'b0;
      addr_i = '0;
      #1;
      checkOutput("reset_ack", ack_o, 1'b0);
      checkOutput("reset_mem_rd", mem_rd_o, 1'b0);
      checkOutput("reset_mem_addr", mem_addr_o, 32'h0);
      checkOutput("reset_data", data_o, 256'h0);
      checkOutput("reset_err", err_o, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      $display("[TB] zero-wait fill and stale request");
      memMode = 1; stallAfter = 8;
      applyStimulus(32'h0000_0047, 8, 1'b0, lat);
      checkOutput("zero_wait_latency", lat, 9);
      releaseRd(5);
      applyStimulus(32'h0000_0020, 8, 1'b0, lat);
      checkOutput("second_req_latency", lat, 9);
      releaseRd(1);

      $display("[TB] wait states");
      memMode = 3;
      applyStimulus(32'h0000_00E0, 8, 1'b0, lat);
      checkOutput("wait_state_slower", lat > 9, 1'b1);
      checkOutput("wait_state_no_err", err_o, 1'b0);
      releaseRd(1);

      $display("[TB] timeout");
      memMode = 1; stallAfter = 3;
      applyStimulus(32'h0000_01C4, 3, 1'b0, lat);
      checkOutput("timeout_latency", lat, 20);
      checkOutput("timeout_err", err_o, 1'b1);
      releaseRd(1);
      stallAfter = 8;
      applyStimulus(32'h0000_0060, 8, 1'b0, lat);
      checkOutput("after_timeout_latency", lat, 9);
      checkOutput("err_sticky", err_o, 1'b1);
      releaseRd(1);

      $display("[TB] reset mid-fetch");
      @(negedge clk);
      wordsGiven = 0;
      addr_i = 32'h0000_0100;
      rd_i = 1'b1;
      expQ.push_back(expectLine(32'h0000_0100, 8));
      @(posedge clk);
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b0;
      rd_i = 1'b0;
      expQ.delete();
      #1;
      checkOutput("midreset_mem_rd", mem_rd_o, 1'b0);
      checkOutput("midreset_ack", ack_o, 1'b0);
      checkOutput("midreset_data", data_o, 256'h0);
      checkOutput("midreset_err", err_o, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checkOutput("post_reset_idle", mem_rd_o, 1'b0);
      end
      applyStimulus(32'h0000_0100, 8, 1'b0, lat);
      checkOutput("post_reset_latency", lat, 9);
      releaseRd(1);

      $display("[TB] rd_i toggled during fetch");
      memMode = 3;
      ackBefore = ackCount;
      applyStimulus(32'h0000_0BA0, 8, 1'b1, lat);
      releaseRd(1);
      repeat (20) @(negedge clk);
      checkOutput("toggle_single_ack", ackCount - ackBefore, 1);
      checkOutput("scoreboard_empty", expQ.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/line_fill_responder.md
Name: line_fill_responder

Overview:
- Memory-side responder for the instruction-cache line-fill interface.
- Accepts a line read request (rd_i, addr_i) from the cache and fetches the 8 words of the 32-byte line over a 32-bit word bus.
- Assembles the words into a 256-bit line and returns it with a one-cycle ack_o pulse.
- Sits between inst_cache and the system memory/bus adapter.

Parameters:
- LINE_WORDS, 8: 32-bit words per cache line (fixed at 8 in this revision).
- TIMEOUT, 255: maximum cycles to wait for mem_valid_i on one word before aborting.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-low.
- addr_i  in  32  cache line address; bits [4:0] ignored.
- rd_i  in  1  line read request; held by the cache until ack_o.
- data_o  out  256  assembled line; word k (byte address base+4k) in bits [32k+31:32k].
- ack_o  out  1  one-cycle pulse: data_o holds the complete requested line.
- mem_addr_o  out  32  word address on the memory bus.
- mem_rd_o  out  1  word read strobe.
- mem_data_i  in  32  word read data.
- mem_valid_i  in  1  mem_data_i valid for the current mem_addr_o.
- err_o  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, data_o=0, ack_o=0, mem_rd_o=0, mem_addr_o=0, err_o=0, word index=0, timeout counter=0. A reset mid-fetch drops mem_rd_o immediately and discards the partial line.
- States: IDLE, FETCH, ACK, DRAIN.
- IDLE:
  - On a rising edge with rd_i=1, latch base = {addr_i[31:5], 5'b0}.
  - Set mem_addr_o=base, mem_rd_o=1, index=0, then go to FETCH.
- FETCH:
  - mem_rd_o is held at 1.
  - On each edge with mem_valid_i=1:
    - Write mem_data_i into data_o word[index] and reset the timeout counter.
    - If index<7: index+1 and mem_addr_o+4.
    - If index=7: drop mem_rd_o and go to ACK.
  - The request is committed once latched; rd_i is ignored in FETCH.
  - Timeout: if mem_valid_i stays 0 for TIMEOUT consecutive cycles:
    - Set err_o=1 and drop mem_rd_o.
    - Zero the unfetched words of data_o and go to ACK, so the cache never hangs.
- ACK: ack_o=1 for exactly one cycle, then go to DRAIN.
- DRAIN: stay until rd_i is sampled 0, then go to IDLE. The cache must drop rd_i for at least one cycle between requests, so a stale rd_i after ack_o is never re-served.
- Latency: rd_i sampled at edge N. With zero-wait memory (mem_valid_i constantly 1), words are captured at edges N+1..N+8 and ack_o is high in the cycle after edge N+9. Each memory wait cycle adds one cycle.
- data_o is stable from ACK until the next fill begins; it is valid only while ack_o=1. Word writes within a fill are in strictly ascending address order.
- Address arithmetic is 32-bit. A fill never crosses the 32-byte line: index is a 3-bit counter and mem_addr_o bits [4:2] equal the index.
- mem_valid_i outside FETCH is ignored.

Decomposition:
- Shared package soc_mem_pkg:
  - LINE_BYTES=32, LINE_OFFSET_BITS=5, LINE_WORDS=8.
  - The responder state enum (IDLE, FETCH, ACK, DRAIN).
  - The same package is used by inst_cache.
- No sub-module required. The word-index/timeout counter pair can stay inline.

Test Plan:
- Zero-wait fill: rd_i=1, addr_i=32'h0000_0047, memory returns word = address → mem_addr_o sweeps 0x40..0x5C. ack_o is high in the cycle after edge N+9. data_o[31:0]=0x40 and data_o[255:224]=0x5C.
- Wait states: mem_valid_i asserted every 3rd cycle, addr_i=32'h0000_00E0 → eight words captured in order, ack_o is a single pulse, err_o stays 0.
- Stale request: rd_i held high 5 cycles after ack_o → no new mem_rd_o until rd_i drops. A second request to 0x20 after a 1-cycle gap returns the line at 0x20..0x3C.
- Timeout: TIMEOUT=16, memory stalls after word 2 → err_o=1 after 16 idle cycles. ack_o pulses, data_o words 3..7 = 0, and the next request is served normally.
- Reset mid-fetch: rst low during word 4 → mem_rd_o, ack_o and data_o are 0 immediately. After release, the FSM is in IDLE and a new request completes correctly.
- rd_i toggled during FETCH → ignored. Exactly one ack_o for the latched line.
